// File: rtl/cmd_cfg.sv
// rtl/cmd_cfg.sv - command dispatcher: setpoints, ESC spin-up/calibration sequencing, comm watchdog
//
// Purpose:
//   Consumes 24-bit commands (8-bit opcode + 16-bit data) from the command
//   receiver, updates the flight-control setpoints, sequences ESC spin-up
//   followed by inertial calibration, returns a one-byte response and runs
//   a communication watchdog that zeroes the setpoints when commands stop.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_rdy, cmd, data command handshake from the receiver (opcode + parameter)
//   clr_cmd_rdy        one-cycle pulse, command consumed (combinational)
//   resp, send_resp    response byte and its one-cycle transmit strobe
//   resp_sent          transmitter finished sending resp
//   cal_done           inertial calibration finished (pulse)
//   strt_cal           one-cycle pulse starting inertial calibration
//   inertial_cal       high while calibration is in progress
//   motors_off         forces all motor drives to zero
//   d_ptch/d_roll/d_yaw signed setpoints, thrst unsigned thrust setpoint

module cmd_cfg #(
  parameter int FAST_SIM = 0,
  parameter int RAMP_W   = 19,
  parameter int WD_W     = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        clr_cmd_rdy,
  output logic [7:0]  resp,
  output logic        send_resp,
  input  logic        resp_sent,
  input  logic        cal_done,
  output logic        strt_cal,
  output logic        inertial_cal,
  output logic        motors_off,
  output logic [15:0] d_ptch,
  output logic [15:0] d_roll,
  output logic [15:0] d_yaw,
  output logic [8:0]  thrst
);

  // Simulation builds collapse both long counters to 9 bits.
  localparam int RW = (FAST_SIM != 0) ? 9 : RAMP_W;
  localparam int WW = (FAST_SIM != 0) ? 9 : WD_W;

  localparam logic [7:0] OP_SET_PTCH  = 8'h02;
  localparam logic [7:0] OP_SET_ROLL  = 8'h03;
  localparam logic [7:0] OP_SET_YAW   = 8'h04;
  localparam logic [7:0] OP_SET_THRST = 8'h05;
  localparam logic [7:0] OP_CALIBRATE = 8'h06;
  localparam logic [7:0] OP_EMER_LAND = 8'h07;
  localparam logic [7:0] OP_MTRS_OFF  = 8'h08;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_BAD = 8'hEE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    CAL  = 2'd2,
    TX   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   ramp_q, ramp_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [15:0]     d_ptch_q, d_ptch_d;
  logic [15:0]     d_roll_q, d_roll_d;
  logic [15:0]     d_yaw_q, d_yaw_d;
  logic [8:0]      thrst_q, thrst_d;
  logic            motors_off_q, motors_off_d;
  logic            inertial_cal_q, inertial_cal_d;
  logic            send_resp_q, send_resp_d;
  logic            strt_cal_q, strt_cal_d;
  logic [7:0]      resp_q, resp_d;
  logic            accept;
  logic            wd_sat;

  assign wd_sat = &wd_q;

  always_comb begin
    state_d        = state_q;
    ramp_d         = ramp_q;
    wd_d           = wd_q;
    d_ptch_d       = d_ptch_q;
    d_roll_d       = d_roll_q;
    d_yaw_d        = d_yaw_q;
    thrst_d        = thrst_q;
    motors_off_d   = motors_off_q;
    inertial_cal_d = inertial_cal_q;
    resp_d         = resp_q;
    send_resp_d    = 1'b0;
    strt_cal_d     = 1'b0;
    accept         = 1'b0;

    // Watchdog: any pending command counts as link activity.
    if (cmd_rdy) begin
      wd_d = '0;
    end else if (!wd_sat) begin
      wd_d = wd_q + 1'b1;
    end

    // Zeroing is applied first so that a command accepted on the same
    // edge overwrites it below.
    if (wd_sat) begin
      d_ptch_d = 16'h0000;
      d_roll_d = 16'h0000;
      d_yaw_d  = 16'h0000;
      thrst_d  = 9'h000;
    end

    case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          accept = 1'b1;
          if (cmd == OP_CALIBRATE) begin
            motors_off_d = 1'b0;
            ramp_d       = '0;
            state_d      = RAMP;
          end else begin
            resp_d      = RESP_ACK;
            send_resp_d = 1'b1;
            state_d     = TX;
            case (cmd)
              OP_SET_PTCH:  d_ptch_d = data;
              OP_SET_ROLL:  d_roll_d = data;
              OP_SET_YAW:   d_yaw_d  = data;
              OP_SET_THRST: thrst_d  = data[8:0];
              OP_EMER_LAND: begin
                d_ptch_d = 16'h0000;
                d_roll_d = 16'h0000;
                d_yaw_d  = 16'h0000;
                thrst_d  = 9'h000;
              end
              OP_MTRS_OFF:  motors_off_d = 1'b1;
              default:      resp_d = RESP_BAD;
            endcase
          end
        end
      end

      RAMP: begin
        ramp_d = ramp_q + 1'b1;
        if (&ramp_q) begin
          strt_cal_d     = 1'b1;
          inertial_cal_d = 1'b1;
          state_d        = CAL;
        end
      end

      CAL: begin
        if (cal_done) begin
          inertial_cal_d = 1'b0;
          resp_d         = RESP_ACK;
          send_resp_d    = 1'b1;
          state_d        = TX;
        end
      end

      TX: begin
        if (resp_sent) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ramp_q         <= '0;
      wd_q           <= '0;
      d_ptch_q       <= 16'h0000;
      d_roll_q       <= 16'h0000;
      d_yaw_q        <= 16'h0000;
      thrst_q        <= 9'h000;
      motors_off_q   <= 1'b1;
      inertial_cal_q <= 1'b0;
      send_resp_q    <= 1'b0;
      strt_cal_q     <= 1'b0;
      resp_q         <= RESP_ACK;
    end else begin
      state_q        <= state_d;
      ramp_q         <= ramp_d;
      wd_q           <= wd_d;
      d_ptch_q       <= d_ptch_d;
      d_roll_q       <= d_roll_d;
      d_yaw_q        <= d_yaw_d;
      thrst_q        <= thrst_d;
      motors_off_q   <= motors_off_d;
      inertial_cal_q <= inertial_cal_d;
      send_resp_q    <= send_resp_d;
      strt_cal_q     <= strt_cal_d;
      resp_q         <= resp_d;
    end
  end

  assign clr_cmd_rdy  = accept;
  assign resp         = resp_q;
  assign send_resp    = send_resp_q;
  assign strt_cal     = strt_cal_q;
  assign inertial_cal = inertial_cal_q;
  assign motors_off   = motors_off_q;
  assign d_ptch       = d_ptch_q;
  assign d_roll       = d_roll_q;
  assign d_yaw        = d_yaw_q;
  assign thrst        = thrst_q;

endmodule

// File: doc/cmd_cfg.md
Name: cmd_cfg

Overview:
- Command dispatcher between the BLE/UART command receiver and the flight-control datapath.
- Consumes each 24-bit command (8-bit opcode + 16-bit data) and updates the pitch/roll/yaw/thrust setpoints.
- Sequences ESC spin-up and inertial calibration, and returns an 8-bit response over the UART transmitter.
- Runs a communication watchdog that forces a landing when commands stop arriving.

Parameters:
FAST_SIM, 0, 1 shortens the ramp and watchdog counters for simulation.
RAMP_W, 19, ramp counter width when FAST_SIM=0 (2^19 cycles ESC spin-up wait); 9 when FAST_SIM=1.
WD_W, 26, watchdog counter width when FAST_SIM=0 (~1.34 s at 50 MHz); 9 when FAST_SIM=1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_rdy  in  1  24-bit command available
cmd  in  8  opcode
data  in  16  command parameter
clr_cmd_rdy  out  1  one-cycle pulse: command consumed
resp  out  8  response byte: 0xA5 ack, 0xEE unknown opcode
send_resp  out  1  one-cycle pulse: transmit resp
resp_sent  in  1  response transmission complete
cal_done  in  1  inertial calibration finished, one-cycle pulse
strt_cal  out  1  one-cycle pulse: start inertial calibration
inertial_cal  out  1  high while calibration is in progress
motors_off  out  1  forces all motor drives to zero
d_ptch  out  16  signed desired pitch
d_roll  out  16  signed desired roll
d_yaw  out  16  signed desired yaw
thrst  out  9  unsigned desired thrust

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). Every output and register is initialised by rst_n.
- Reset values: all setpoints 0; motors_off=1; inertial_cal=0; send_resp, strt_cal and clr_cmd_rdy all 0; resp=0xA5; state IDLE; both counters 0.
- Opcodes:
  - 0x02 SET_PTCH: d_ptch<=data.
  - 0x03 SET_ROLL: d_roll<=data.
  - 0x04 SET_YAW: d_yaw<=data.
  - 0x05 SET_THRST: thrst<=data[8:0].
  - 0x06 CALIBRATE.
  - 0x07 EMER_LAND: all four setpoints <=0.
  - 0x08 MTRS_OFF: motors_off<=1.
  - Any other opcode: no register change, resp=0xEE.
- States: IDLE, RAMP, CAL, TX.
- IDLE:
  - Command accept (cycle N) when cmd_rdy=1: clr_cmd_rdy=1 combinationally.
  - Opcodes other than 0x06: the setpoint/motors_off update and the resp value are registered at edge N+1. send_resp=1 during cycle N+1 only. Next state is TX.
  - 0x06: at edge N+1, motors_off<=0 and the ramp counter clears. Next state is RAMP. No response is sent yet.
- RAMP: the ramp counter increments each cycle. When it reaches all-ones, strt_cal pulses for 1 cycle, inertial_cal<=1, and the next state is CAL.
- CAL: wait for cal_done=1. Then inertial_cal<=0, resp<=0xA5, send_resp pulses on the next cycle, and the next state is TX.
- TX: hold until resp_sent=1, then go to IDLE.
- Commands arriving outside IDLE:
  - cmd_rdy is not cleared while the state is RAMP, CAL or TX.
  - The command stays pending and is accepted on the first IDLE cycle.
  - At most one response is outstanding at a time.
- Watchdog:
  - Counter cleared whenever cmd_rdy=1; otherwise increments, saturating at all-ones.
  - At saturation, all four setpoints are forced to 0 every cycle. No response is sent. motors_off is unchanged.
  - If a command update and a watchdog zeroing coincide on the same edge, the command wins (cmd_rdy also clears the counter).
- Calibration and watchdog: during RAMP and CAL the watchdog still runs, but setpoint zeroing only affects the setpoints. The calibration sequence continues regardless.
- Additional cal_done pulses:
  - cal_done outside CAL is ignored.
  - Reset mid-calibration aborts it: inertial_cal=0, motors_off=1.
- Arithmetic: setpoints are stored verbatim (no saturation). thrst takes data[8:0], and data[15:9] is discarded.

Test Plan:
- Reset released; cmd 0x02, data 0x0123 -> clr_cmd_rdy 1 cycle. d_ptch=0x0123 and send_resp high the next cycle with resp=0xA5. Other setpoints stay 0. Return to IDLE after resp_sent.
- cmd 0x05, data 0xFFFF -> thrst=0x1FF. cmd 0x07 -> d_ptch, d_roll, d_yaw and thrst all 0, ack 0xA5.
- FAST_SIM=1; cmd 0x06 -> motors_off falls the next cycle. strt_cal pulses exactly 512 cycles later and inertial_cal rises. cal_done pulse -> inertial_cal=0, send_resp with 0xA5.
- cmd 0x03 presented while in TX with resp_sent withheld -> clr_cmd_rdy stays 0. Assert resp_sent -> command accepted on the first IDLE cycle and d_roll updated.
- FAST_SIM=1; thrst=0x100, d_yaw=0x0040, then no cmd_rdy for 512 cycles -> all setpoints become 0, no send_resp. A following cmd 0x05, data 0x0080 -> thrst=0x080.
- cmd 0x1F -> clr_cmd_rdy pulses, no setpoint change, send_resp with resp=0xEE. Asserting rst_n=0 during CAL -> inertial_cal=0, motors_off=1, state IDLE immediately.
